// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared types and constants for the M-extension issue controller.
//             funct3 decode enum, controller state enum, multiply iteration
//             count.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    localparam int MUL_ITERS = 32;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_issue_ctrl_if
//  Purpose  : EX-stage <-> MDU request/response bundle.
//  Ports    : master = EX stage (drives request, sees stall/result)
//             slave  = mdu_issue_ctrl
//  Revision : 1.0  initial release
// ============================================================================
interface mdu_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mdu_start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            flush;
    logic            mdu_busy;
    logic            mdu_valid;
    logic [XLEN-1:0] mdu_result;
    logic [4:0]      mdu_rd;

    modport master (
        output mdu_start, funct3, rs1_data, rs2_data, rd_addr, flush,
        input  mdu_busy, mdu_valid, mdu_result, mdu_rd
    );

    modport slave (
        input  mdu_start, funct3, rs1_data, rs2_data, rd_addr, flush,
        output mdu_busy, mdu_valid, mdu_result, mdu_rd
    );
endinterface : mdu_issue_ctrl_if
`default_nettype wire

// File: rtl/mdu_issue_ctrl_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_iter
//  Purpose  : Sign-handling radix-2 shift-add multiplier, MUL_ITERS cycles.
//  Ports    : clk, rst       clock / sync active-high reset
//             kill           abandon any operation in flight
//             start          load operands and op (one-cycle pulse)
//             op             funct3 of the multiply
//             a, b           operands
//             done           high on the cycle of the final iteration
//             result         selected/negated product, valid while done
//  Revision : 1.0  initial release
// ============================================================================
module mul_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              kill,
    input  wire logic              start,
    input  wire mdu_funct3_e       op,
    input  wire logic [XLEN-1:0]   a,
    input  wire logic [XLEN-1:0]   b,
    output logic                   done,
    output logic [XLEN-1:0]        result
);
    localparam int              c_CNT_W = $clog2(MUL_ITERS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MUL_ITERS - 1);

    mdu_funct3_e       r_op;
    logic              r_neg;
    logic              r_run;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;

    assign w_a_signed = (op == MDU_MULH) || (op == MDU_MULHSU);
    assign w_b_signed = (op == MDU_MULH);
    assign w_a_neg    = w_a_signed && a[XLEN-1];
    assign w_b_neg    = w_b_signed && b[XLEN-1];
    // -2^(XLEN-1) negates to itself, which read as unsigned is the right magnitude.
    assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;

    // The final add is folded into the output so the product is available on
    // the same edge that retires the last iteration.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    assign result     = (r_op == MDU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign done       = r_run && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            r_op     <= MDU_MUL;
            r_neg    <= 1'b0;
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_op     <= op;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule : mul_iter
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_issue_ctrl
//  Purpose  : M-extension EX-stage controller. Multiplies run on mul_iter;
//             divides/remainders are issued to an external combinational
//             divider_32bit as a registered multicycle path of DIV_CYCLES.
//  Ports    : clk, rst        clock / sync active-high reset
//             ex (slave)      start/funct3/operands/rd/flush in,
//                             busy/valid/result/rd out
//             div_opcode      funct3[1:0] of the accepted divide
//             div_operand1/2  registered divider operands
//             result_divide   divider result
//  Config   : MDU_DIV_ZERO_FAST_EN - divide by zero completes in one cycle
//             with the architectural result instead of using the divider.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mdu_issue_ctrl_if.slave      ex,
    output logic [1:0]           div_opcode,
    output logic [XLEN-1:0]      div_operand1,
    output logic [XLEN-1:0]      div_operand2,
    input  wire logic [XLEN-1:0] result_divide
);
    localparam int                 c_CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(DIV_CYCLES - 1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_next;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [1:0]         r_op;
    logic [4:0]         r_rd;
    logic [XLEN-1:0]    r_res;
    logic [c_CNT_W-1:0] r_cnt;

    mdu_funct3_e        w_f3;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [XLEN-1:0]    w_mul_result;
    logic               w_cap;
    logic [XLEN-1:0]    w_cap_val;

    assign w_f3     = mdu_funct3_e'(ex.funct3);
    // Flush beats a simultaneous start: nothing is accepted that cycle.
    assign w_accept = (r_state == ST_IDLE) && ex.mdu_start && !ex.flush;

    assign ex.mdu_busy   = w_accept || (r_state == ST_MUL) || (r_state == ST_DIV);
    assign ex.mdu_valid  = (r_state == ST_DONE);
    assign ex.mdu_result = r_res;
    assign ex.mdu_rd     = r_rd;

    assign div_opcode    = r_op;
    assign div_operand1  = r_a;
    assign div_operand2  = r_b;

    mul_iter #(
        .XLEN   (XLEN)
    ) u_mul_iter (
        .clk    (clk),
        .rst    (rst),
        .kill   (ex.flush),
        .start  (w_mul_start),
        .op     (w_f3),
        .a      (ex.rs1_data),
        .b      (ex.rs2_data),
        .done   (w_mul_done),
        .result (w_mul_result)
    );

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_cap        = 1'b0;
        w_cap_val    = result_divide;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_f3[2]) begin
                        w_state_next = ST_MUL;
                        w_mul_start  = 1'b1;
                    end else begin
`ifdef MDU_DIV_ZERO_FAST_EN
                        if (ex.rs2_data == '0) begin
                            w_state_next = ST_DONE;
                            w_cap        = 1'b1;
                            w_cap_val    = ((w_f3 == MDU_DIV) || (w_f3 == MDU_DIVU)) ?
                                           '1 : ex.rs1_data;
                        end else begin
                            w_state_next = ST_DIV;
                        end
`else
                        w_state_next = ST_DIV;
`endif
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_DONE;
                    w_cap        = 1'b1;
                    w_cap_val    = w_mul_result;
                end
            end
            ST_DIV: begin
                // Divider inputs have been stable DIV_CYCLES cycles by this edge.
                if (r_cnt == c_DIV_LAST) begin
                    w_state_next = ST_DONE;
                    w_cap        = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (ex.flush) begin
            w_state_next = ST_IDLE;
            w_cap        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_rd  <= '0;
            r_res <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= ex.rs1_data;
                r_b   <= ex.rs2_data;
                r_op  <= ex.funct3[1:0];
                r_rd  <= ex.rd_addr;
                r_cnt <= '0;
            end else if (r_state == ST_DIV) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_cap) begin
                r_res <= w_cap_val;
            end
        end
    end

endmodule : mdu_issue_ctrl
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_issue_ctrl
//  Purpose  : Directed self-checking bench for mdu_issue_ctrl with a
//             behavioural stand-in for divider_32bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    localparam int XLEN       = 32;
    localparam int DIV_CYCLES = 4;
    localparam int MLAT       = MUL_ITERS + 1;
    localparam int DLAT       = DIV_CYCLES + 1;
`ifdef MDU_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = DIV_CYCLES + 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      div_opcode;
    logic [XLEN-1:0] div_operand1;
    logic [XLEN-1:0] div_operand2;
    logic [XLEN-1:0] result_divide;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl_if #(.XLEN(XLEN)) ex ();

    mdu_issue_ctrl #(
        .XLEN          (XLEN),
        .DIV_CYCLES    (DIV_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex            (ex.slave),
        .div_opcode    (div_opcode),
        .div_operand1  (div_operand1),
        .div_operand2  (div_operand2),
        .result_divide (result_divide)
    );

    // RISC-V divider behaviour (div-by-zero and signed overflow included).
    always_comb begin
        result_divide = '0;
        case (div_opcode)
            2'b00: begin
                if (div_operand2 == 32'd0)
                    result_divide = 32'hFFFF_FFFF;
                else if (div_operand1 == 32'h8000_0000 && div_operand2 == 32'hFFFF_FFFF)
                    result_divide = div_operand1;
                else
                    result_divide = 32'($signed(div_operand1) / $signed(div_operand2));
            end
            2'b01: begin
                if (div_operand2 == 32'd0) result_divide = 32'hFFFF_FFFF;
                else                       result_divide = div_operand1 / div_operand2;
            end
            2'b10: begin
                if (div_operand2 == 32'd0)
                    result_divide = div_operand1;
                else if (div_operand1 == 32'h8000_0000 && div_operand2 == 32'hFFFF_FFFF)
                    result_divide = 32'd0;
                else
                    result_divide = 32'($signed(div_operand1) % $signed(div_operand2));
            end
            default: begin
                if (div_operand2 == 32'd0) result_divide = div_operand1;
                else                       result_divide = div_operand1 % div_operand2;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle (t) and follow it to the valid cycle
    // t+lat and the idle cycle after it.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int lat,
                          input logic [31:0] exp);
        ex.funct3    = f3;
        ex.rs1_data  = a;
        ex.rs2_data  = b;
        ex.rd_addr   = rd;
        ex.mdu_start = 1'b1;
        #1;
        chk({tag, "_busy_t"}, 32'(ex.mdu_busy), 32'd1);
        tick();
        ex.mdu_start = 1'b0;
        ex.rs1_data  = ~a;
        ex.rs2_data  = ~b;
        ex.rd_addr   = ~rd;
        for (int c = 1; c < lat; c++) begin
            #1;
            chk({tag, "_busy"}, 32'(ex.mdu_busy), 32'd1);
            chk({tag, "_novalid"}, 32'(ex.mdu_valid), 32'd0);
            if (f3[2]) begin
                chk({tag, "_op1"}, div_operand1, a);
                chk({tag, "_op2"}, div_operand2, b);
                chk({tag, "_opc"}, 32'(div_opcode), 32'(f3[1:0]));
            end
            tick();
        end
        #1;
        chk({tag, "_valid"}, 32'(ex.mdu_valid), 32'd1);
        chk({tag, "_result"}, ex.mdu_result, exp);
        chk({tag, "_rd"}, 32'(ex.mdu_rd), 32'(rd));
        chk({tag, "_busy_done"}, 32'(ex.mdu_busy), 32'd0);
        tick();
        chk({tag, "_valid_drop"}, 32'(ex.mdu_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        ex.mdu_start = 1'b0;
        ex.flush     = 1'b0;
        ex.funct3    = 3'b000;
        ex.rs1_data  = '0;
        ex.rs2_data  = '0;
        ex.rd_addr   = '0;
        tick();
        tick();
        chk("rst_busy",   32'(ex.mdu_busy),   32'd0);
        chk("rst_valid",  32'(ex.mdu_valid),  32'd0);
        chk("rst_result", ex.mdu_result,      32'd0);
        chk("rst_rd",     32'(ex.mdu_rd),     32'd0);
        chk("rst_opc",    32'(div_opcode),    32'd0);
        chk("rst_op1",    div_operand1,       32'd0);
        chk("rst_op2",    div_operand2,       32'd0);
        rst = 1'b0;
        tick();

        // Multiplies
        run_op("mul_7x6",      3'b000, 32'd7,         32'd6,         5'd3,  MLAT, 32'd42);
        run_op("mulh_m1x2",    3'b001, 32'hFFFF_FFFF, 32'd2,         5'd4,  MLAT, 32'hFFFF_FFFF);
        run_op("mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  MLAT, 32'hFFFF_FFFE);
        run_op("mulhsu_m1x2",  3'b010, 32'hFFFF_FFFF, 32'd2,         5'd6,  MLAT, 32'hFFFF_FFFF);
        run_op("mul_min_m1",   3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  MLAT, 32'h8000_0000);
        run_op("mulh_min_m1",  3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  MLAT, 32'h0000_0000);
        run_op("mulh_neg_pos", 3'b001, 32'hFFFF_FFFD, 32'd5,         5'd31, MLAT, 32'hFFFF_FFFF);

        // Divides
        run_op("div_m20_3",    3'b100, 32'hFFFF_FFEC, 32'd3,         5'd10, DLAT, 32'hFFFF_FFFA);
        run_op("remu_20_3",    3'b111, 32'd20,        32'd3,         5'd11, DLAT, 32'd2);
        run_op("rem_m20_3",    3'b110, 32'hFFFF_FFEC, 32'd3,         5'd12, DLAT, 32'hFFFF_FFFE);
        run_op("div_5_0",      3'b100, 32'd5,         32'd0,         5'd13, ZLAT, 32'hFFFF_FFFF);
        run_op("divu_5_0",     3'b101, 32'd5,         32'd0,         5'd14, ZLAT, 32'hFFFF_FFFF);
        run_op("rem_5_0",      3'b110, 32'd5,         32'd0,         5'd15, ZLAT, 32'd5);
        run_op("remu_7_0",     3'b111, 32'd7,         32'd0,         5'd16, ZLAT, 32'd7);

        // Flush of a multiply at t+10, then a divide accepted at t+11
        ex.funct3    = 3'b000;
        ex.rs1_data  = 32'd3;
        ex.rs2_data  = 32'd4;
        ex.rd_addr   = 5'd9;
        ex.mdu_start = 1'b1;
        tick();
        ex.mdu_start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        #1;
        chk("flush_busy_before", 32'(ex.mdu_busy), 32'd1);
        ex.flush = 1'b1;
        tick();
        ex.flush = 1'b0;
        #1;
        chk("flush_busy_after",  32'(ex.mdu_busy),  32'd0);
        chk("flush_no_valid",    32'(ex.mdu_valid), 32'd0);
        run_op("divu_9_2_after_flush", 3'b101, 32'd9, 32'd2, 5'd17, DLAT, 32'd4);
        for (int c = 0; c < 24; c++) begin
            chk("flush_no_stale_valid", 32'(ex.mdu_valid), 32'd0);
            tick();
        end

        // Reset in the middle of a divide
        ex.funct3    = 3'b100;
        ex.rs1_data  = 32'd100;
        ex.rs2_data  = 32'd7;
        ex.rd_addr   = 5'd20;
        ex.mdu_start = 1'b1;
        tick();
        ex.mdu_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_busy",   32'(ex.mdu_busy),  32'd0);
        chk("rstmid_valid",  32'(ex.mdu_valid), 32'd0);
        chk("rstmid_result", ex.mdu_result,     32'd0);
        chk("rstmid_rd",     32'(ex.mdu_rd),    32'd0);
        chk("rstmid_opc",    32'(div_opcode),   32'd0);
        chk("rstmid_op1",    div_operand1,      32'd0);
        chk("rstmid_op2",    div_operand2,      32'd0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rstmid_no_stale_valid", 32'(ex.mdu_valid), 32'd0);
        end

        // Start together with flush in IDLE is not accepted
        ex.funct3    = 3'b101;
        ex.rs1_data  = 32'h0000_1234;
        ex.rs2_data  = 32'd5;
        ex.rd_addr   = 5'd21;
        ex.mdu_start = 1'b1;
        ex.flush     = 1'b1;
        #1;
        chk("startflush_busy", 32'(ex.mdu_busy), 32'd0);
        tick();
        ex.mdu_start = 1'b0;
        ex.flush     = 1'b0;
        chk("startflush_op1", div_operand1,       32'd0);
        chk("startflush_rd",  32'(ex.mdu_rd),     32'd0);
        for (int c = 0; c < 8; c++) begin
            chk("startflush_busy_idle", 32'(ex.mdu_busy),  32'd0);
            chk("startflush_no_valid",  32'(ex.mdu_valid), 32'd0);
            tick();
        end

        // Still operational afterwards
        run_op("divu_100_7_final", 3'b101, 32'd100, 32'd7, 5'd22, DLAT, 32'd14);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mdu_issue_ctrl
`default_nettype wire
